// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int CTRL_W_DEF = 4;
  localparam int DATA_W_DEF = 69;

endpackage

// File: rtl/pipe_entry.sv
// One {valid, ctrl, data} holding register; clear beats load and only zeroes valid/ctrl.
// Latency: 1 cycle load-to-output. No flow control of its own; the owner decides when to load or clear.
module pipe_entry #(
  parameter int                CTRL_W  = 4,
  parameter int                DATA_W  = 69,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= RST_VAL;
    end else if (clr) begin
      // Payload is left alone so a bubble output stays stable.
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with a two-entry skid buffer, registered s_ready_o, 1-cycle latency.
// stall_i acts as downstream not-ready, flush_i empties the stage; PIPE_STAGE_STATS_EN adds stall/xfer counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                CTRL_W  = CTRL_W_DEF,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [CTRL_W-1:0] s_ctrl_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CTRL_W-1:0] m_ctrl_o,
  output logic [DATA_W-1:0] m_data_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       xfer_cnt_o
`endif
);

  pipe_state_t       state, state_nxt;
  logic              rdy, acc;
  logic              ready_q;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] skid_data, main_data_d;

  assign rdy       = m_ready_i & ~stall_i;
  assign acc       = s_valid_i & ready_q;
  assign s_ready_o = ready_q;

  // Main refills from the skid entry whenever the skid holds a beat.
  assign main_ctrl_d = skid_valid ? skid_ctrl : s_ctrl_i;
  assign main_data_d = skid_valid ? skid_data : s_data_i;

  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    main_clr  = 1'b0;
    skid_ld   = 1'b0;
    skid_clr  = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt = FULL;
            main_ld   = 1'b1;
          end
        end
        FULL: begin
          if (acc && rdy) begin
            main_ld = 1'b1;
          end else if (acc) begin
            state_nxt = SKID;
            skid_ld   = 1'b1;
          end else if (rdy) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
          end
        end
        SKID: begin
          if (rdy) begin
            state_nxt = FULL;
            main_ld   = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != SKID);
    end
  end

  pipe_entry #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (main_clr),
    .load    (main_ld),
    .d_valid (1'b1),
    .d_ctrl  (main_ctrl_d),
    .d_data  (main_data_d),
    .q_valid (m_valid_o),
    .q_ctrl  (m_ctrl_o),
    .q_data  (m_data_o)
  );

  pipe_entry #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (skid_clr),
    .load    (skid_ld),
    .d_valid (1'b1),
    .d_ctrl  (s_ctrl_i),
    .d_data  (s_data_i),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, xfer_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else if (m_valid_o) begin
      if (rdy) xfer_cnt_q  <= xfer_cnt_q + 32'd1;
      else     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign xfer_cnt_o  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_pipe_skid_stage;
  localparam int CTRL_W = 4;
  localparam int DATA_W = 69;
  localparam int E_W    = CTRL_W + DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              stall_i = 1'b0, flush_i = 1'b0;
  logic              s_valid_i = 1'b0, m_ready_i = 1'b0;
  logic [CTRL_W-1:0] s_ctrl_i = '0;
  logic [DATA_W-1:0] s_data_i = '0;
  logic              s_ready_o, m_valid_o;
  logic [CTRL_W-1:0] m_ctrl_o;
  logic [DATA_W-1:0] m_data_o;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt_o, xfer_cnt_o;
  logic [31:0]       stall_m = '0, xfer_m = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_VAL('0)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_ctrl_i  (s_ctrl_i),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_ctrl_o  (m_ctrl_o),
    .m_data_o  (m_data_o)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .xfer_cnt_o  (xfer_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two beats whose input ready is
  // recomputed from its occupancy after each edge.
  logic [E_W-1:0]    q[$];
  bit                ready_m = 1'b1;
  logic [DATA_W-1:0] last_data_m = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q.delete();
      ready_m     = 1'b1;
      last_data_m = '0;
`ifdef PIPE_STAGE_STATS_EN
      stall_m = '0;
      xfer_m  = '0;
`endif
    end else begin
      bit down_rdy, had_head, take;
      down_rdy = m_ready_i && !stall_i;
      had_head = (q.size() > 0);
      take     = s_valid_i && ready_m;
`ifdef PIPE_STAGE_STATS_EN
      if (had_head) begin
        if (down_rdy) xfer_m++;
        else          stall_m++;
      end
`endif
      if (flush_i) begin
        q.delete();
      end else begin
        if (had_head && down_rdy) void'(q.pop_front());
        if (take) q.push_back({s_ctrl_i, s_data_i});
      end
      ready_m = (q.size() < 2);
    end
  end

  always @(negedge clk_i) begin
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [DATA_W-1:0] ed;
    ev = (q.size() > 0);
    ec = '0;
    ed = last_data_m;
    if (ev) begin
      ec = q[0][E_W-1:DATA_W];
      ed = q[0][DATA_W-1:0];
      last_data_m = ed;
    end
    check("m_valid", 96'(m_valid_o), 96'(ev));
    check("s_ready", 96'(s_ready_o), 96'(ready_m));
    check("m_ctrl",  96'(m_ctrl_o),  96'(ec));
    check("m_data",  96'(m_data_o),  96'(ed));
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt", 96'(stall_cnt_o), 96'(stall_m));
    check("xfer_cnt",  96'(xfer_cnt_o),  96'(xfer_m));
`endif
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    stall_i   = 1'b0;
    flush_i   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic beat(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    s_valid_i = 1'b1;
    s_ctrl_i  = c;
    s_data_i  = d;
  endtask

  initial begin
    logic [95:0] r;

    do_reset();
    check("reset_valid", 96'(m_valid_o), 96'(0));
    check("reset_ready", 96'(s_ready_o), 96'(1));
    check("reset_data",  96'(m_data_o),  96'(0));

    // Streaming 1..8 with continuous ready
    m_ready_i = 1'b1;
    beat(4'h3, 69'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("stream_data",  96'(m_data_o),  96'(k));
      check("stream_ready", 96'(s_ready_o), 96'(1));
      s_data_i = DATA_W'(k + 1);
    end
    s_valid_i = 1'b0;
    step();
    check("stream_drain", 96'(m_valid_o), 96'(0));

    // Backpressure: A held, B skidded, C pending
    do_reset();
    beat(4'h5, 69'hA);
    step();
    beat(4'h6, 69'hB);
    step();
    check("bp_ready_low", 96'(s_ready_o), 96'(0));
    check("bp_hold_a",    96'(m_data_o),  96'(69'hA));
    beat(4'h7, 69'hC);
    step();
    check("bp_still_a",   96'(m_data_o),  96'(69'hA));
    m_ready_i = 1'b1;
    step();
    check("bp_b",         96'(m_data_o),  96'(69'hB));
    check("bp_b_ctrl",    96'(m_ctrl_o),  96'(4'h6));
    check("bp_ready_up",  96'(s_ready_o), 96'(1));
    step();
    check("bp_c",         96'(m_data_o),  96'(69'hC));
    s_valid_i = 1'b0;
    step();
    check("bp_empty_ctrl", 96'(m_ctrl_o), 96'(0));

    // Reset while in SKID: outputs clear in the same cycle
    m_ready_i = 1'b0;
    beat(4'h9, 69'h31);
    step();
    beat(4'h9, 69'h32);
    step();
    rst_i = 1'b1;
    #1;
    check("arst_valid", 96'(m_valid_o), 96'(0));
    check("arst_ctrl",  96'(m_ctrl_o),  96'(0));
    check("arst_ready", 96'(s_ready_o), 96'(1));
    do_reset();

    // stall for three edges with m_ready high
    m_ready_i = 1'b1;
    beat(4'h2, 69'h11);
    step();
    stall_i = 1'b1;
    beat(4'h2, 69'h12);
    step();
    check("stall_hold1", 96'(m_data_o),  96'(69'h11));
    check("stall_rdy",   96'(s_ready_o), 96'(0));
    beat(4'h2, 69'h13);
    step();
    step();
    check("stall_hold3", 96'(m_data_o),  96'(69'h11));
    stall_i = 1'b0;
    step();
    check("stall_rel_b", 96'(m_data_o),  96'(69'h12));
    step();
    check("stall_rel_c", 96'(m_data_o),  96'(69'h13));
    s_valid_i = 1'b0;
    step();

    // Flush while in SKID with a same-cycle beat
    do_reset();
    beat(4'h1, 69'h21);
    step();
    beat(4'h1, 69'h22);
    step();
    flush_i = 1'b1;
    stall_i = 1'b1;
    beat(4'hF, 69'h23);
    step();
    check("flush_valid", 96'(m_valid_o), 96'(0));
    check("flush_ctrl",  96'(m_ctrl_o),  96'(0));
    check("flush_ready", 96'(s_ready_o), 96'(1));
    flush_i   = 1'b0;
    stall_i   = 1'b0;
    m_ready_i = 1'b1;
    beat(4'h3, 69'h24);
    step();
    check("flush_next",      96'(m_data_o), 96'(69'h24));
    check("flush_next_ctrl", 96'(m_ctrl_o), 96'(4'h3));
    s_valid_i = 1'b0;
    step();

`ifdef PIPE_STAGE_STATS_EN
    do_reset();
    check("cnt_rst", 96'(xfer_cnt_o), 96'(0));
    beat(4'h1, 69'h41);
    step();
    s_valid_i = 1'b0;
    step();
    step();
    step();
    m_ready_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      beat(4'h1, DATA_W'(64 + k));
      step();
    end
    s_valid_i = 1'b0;
    step();
    check("cnt_xfer5",  96'(xfer_cnt_o),  96'(5));
    check("cnt_stall3", 96'(stall_cnt_o), 96'(3));
    m_ready_i = 1'b0;
    beat(4'h1, 69'h50);
    step();
    s_valid_i = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    stall_m = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    step();
    check("cnt_wrap", 96'(stall_cnt_o), 96'(0));
    m_ready_i = 1'b1;
    step();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      s_valid_i = ($urandom_range(3) != 0);
      m_ready_i = ($urandom_range(2) != 0);
      stall_i   = ($urandom_range(7) == 0);
      flush_i   = ($urandom_range(19) == 0);
      s_ctrl_i  = r[95:92];
      s_data_i  = r[DATA_W-1:0];
      if (i == 300) rst_i = 1'b1;
      if (i == 302) rst_i = 1'b0;
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
